// File: rtl/axil_master.sv
// axil_master: AXI4-Lite master bridging single-beat core start/done requests onto the peripheral bus.
// Define AXIL_RESP_ERR_EN to add WRITE_ERR/READ_ERR reporting of SLVERR/DECERR responses.
module axil_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    START_WRITE,
   input  logic                    START_READ,
   input  logic [ADDR_WIDTH-1:0]   TRANSACTION_WRADDR,
   input  logic [DATA_WIDTH-1:0]   TRANSACTION_WRDATA,
   input  logic [DATA_WIDTH/8-1:0] TRANSACTION_WSTRB,
   input  logic [ADDR_WIDTH-1:0]   TRANSACTION_RADDR,
   output logic [DATA_WIDTH-1:0]   TRANSACTION_RDATA,
   output logic                    DONE_WRITE,
   output logic                    DONE_READ,
   output logic                    BUSY_WRITE,
   output logic                    BUSY_READ,
   output logic [ADDR_WIDTH-1:0]   M_AWADDR,
   output logic [2:0]              M_AWPROT,
   output logic                    M_AWVALID,
   input  logic                    M_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_WSTRB,
   output logic                    M_WVALID,
   input  logic                    M_WREADY,
   input  logic [1:0]              M_BRESP,
   input  logic                    M_BVALID,
   output logic                    M_BREADY,
   output logic [ADDR_WIDTH-1:0]   M_ARADDR,
   output logic [2:0]              M_ARPROT,
   output logic                    M_ARVALID,
   input  logic                    M_ARREADY,
   input  logic [DATA_WIDTH-1:0]   M_RDATA,
   input  logic [1:0]              M_RRESP,
   input  logic                    M_RVALID,
   output logic                    M_RREADY
`ifdef AXIL_RESP_ERR_EN
   ,
   output logic                    WRITE_ERR,
   output logic                    READ_ERR
`endif
);
   localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
   logic [1:0]              w_state_q, w_state_d, r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, rd_cap;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic bready_q, bready_d, done_w_q, done_w_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d, done_r_q, done_r_d;
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q & ~M_AWREADY;
      wvalid_d  = wvalid_q & ~M_WREADY;
      aw_done_d = aw_done_q | (awvalid_q & M_AWREADY);
      w_done_d  = w_done_q | (wvalid_q & M_WREADY);
      bready_d  = bready_q;
      done_w_d  = 1'b0;
      if (w_state_q == W_IDLE && START_WRITE) begin
         w_state_d = W_ADDR;
         awaddr_d  = TRANSACTION_WRADDR;
         wdata_d   = TRANSACTION_WRDATA;
         wstrb_d   = TRANSACTION_WSTRB;
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end else if (w_state_q == W_ADDR && aw_done_d && w_done_d) begin
         w_state_d = W_RESP;
         bready_d  = 1'b1;
      end else if (w_state_q == W_RESP && M_BVALID && bready_q) begin
         w_state_d = W_IDLE;
         bready_d  = 1'b0;
         done_w_d  = 1'b1;
      end
   end
   always_comb begin
      r_state_d = r_state_q;
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rdata_d   = rdata_q;
      done_r_d  = 1'b0;
      if (r_state_q == R_IDLE && START_READ) begin
         r_state_d = R_ADDR;
         araddr_d  = TRANSACTION_RADDR;
         arvalid_d = 1'b1;
      end else if (r_state_q == R_ADDR && M_ARREADY) begin
         r_state_d = R_DATA;
         arvalid_d = 1'b0;
         rready_d  = 1'b1;
      end else if (r_state_q == R_DATA && M_RVALID) begin
         r_state_d = R_IDLE;
         rready_d  = 1'b0;
         done_r_d  = 1'b1;
         rdata_d   = rd_cap;
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         bready_q  <= 1'b0;
         done_w_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         done_r_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         bready_q  <= bready_d;
         done_w_q  <= done_w_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         done_r_q  <= done_r_d;
      end
   end
`ifdef AXIL_RESP_ERR_EN
   // Only SLVERR/DECERR set bit 1 of the response; an errored read returns zero data.
   logic werr_q, rerr_q;
   assign rd_cap = M_RRESP[1] ? '0 : M_RDATA;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         werr_q <= 1'b0;
         rerr_q <= 1'b0;
      end else begin
         werr_q <= done_w_d & M_BRESP[1];
         rerr_q <= done_r_d & M_RRESP[1];
      end
   end
   assign WRITE_ERR = werr_q;
   assign READ_ERR  = rerr_q;
`else
   logic unused_resp;
   assign rd_cap      = M_RDATA;
   assign unused_resp = ^{M_BRESP, M_RRESP};
`endif
   assign TRANSACTION_RDATA = rdata_q;
   assign DONE_WRITE = done_w_q;
   assign DONE_READ  = done_r_q;
   assign BUSY_WRITE = w_state_q != W_IDLE;
   assign BUSY_READ  = r_state_q != R_IDLE;
   assign M_AWADDR   = awaddr_q;
   assign M_AWPROT   = 3'b000;
   assign M_AWVALID  = awvalid_q;
   assign M_WDATA    = wdata_q;
   assign M_WSTRB    = wstrb_q;
   assign M_WVALID   = wvalid_q;
   assign M_BREADY   = bready_q;
   assign M_ARADDR   = araddr_q;
   assign M_ARPROT   = 3'b000;
   assign M_ARVALID  = arvalid_q;
   assign M_RREADY   = rready_q;
endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: scenario tasks against axil_master with a delay-configurable AXI4-Lite slave.
// Builds with or without AXIL_RESP_ERR_EN; the response scenario adapts to the build.
module tb_axil_master;
   logic        CLK = 1'b0, RST_N = 1'b0;
   logic        START_WRITE = 1'b0, START_READ = 1'b0;
   logic [31:0] TRANSACTION_WRADDR = '0, TRANSACTION_WRDATA = '0, TRANSACTION_RADDR = '0;
   logic [3:0]  TRANSACTION_WSTRB = '0;
   logic [31:0] TRANSACTION_RDATA, M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
   logic [3:0]  M_WSTRB;
   logic [2:0]  M_AWPROT, M_ARPROT;
   logic        DONE_WRITE, DONE_READ, BUSY_WRITE, BUSY_READ;
   logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
   logic        M_AWREADY = 1'b0, M_WREADY = 1'b0, M_BVALID = 1'b0, M_ARREADY = 1'b0, M_RVALID = 1'b0;
   logic [1:0]  M_BRESP, M_RRESP;
   logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
   logic [31:0] rdata_v = '0;
   int          dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
   int          aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
   int          checks = 0, failures = 0;
   int          aw_n = 0, dw_n = 0, dr_n = 0;
   logic [31:0] aw_s = '0, w_s = '0, ar_s = '0;
   logic [3:0]  s_s = '0;
`ifdef AXIL_RESP_ERR_EN
   logic        WRITE_ERR, READ_ERR;
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wexp_t;
   typedef struct {logic [31:0] addr; logic [31:0] data;} rexp_t;
   wexp_t wq[$];
   rexp_t rq[$];

   axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .RST_N(RST_N), .START_WRITE(START_WRITE), .START_READ(START_READ),
      .TRANSACTION_WRADDR(TRANSACTION_WRADDR), .TRANSACTION_WRDATA(TRANSACTION_WRDATA),
      .TRANSACTION_WSTRB(TRANSACTION_WSTRB), .TRANSACTION_RADDR(TRANSACTION_RADDR),
      .TRANSACTION_RDATA(TRANSACTION_RDATA), .DONE_WRITE(DONE_WRITE), .DONE_READ(DONE_READ),
      .BUSY_WRITE(BUSY_WRITE), .BUSY_READ(BUSY_READ),
      .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
      .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
      .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
      .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
`ifdef AXIL_RESP_ERR_EN
      , .WRITE_ERR(WRITE_ERR), .READ_ERR(READ_ERR)
`endif
   );

   always #5 CLK = ~CLK;

   assign M_BRESP = bresp_v;
   assign M_RRESP = rresp_v;
   assign M_RDATA = M_RVALID ? rdata_v : 32'hBAD0_BAD0;

   // Slave reacts just after each rising edge; each READY/VALID waits dly_* cycles of the master's request.
   always @(posedge CLK) begin
      #1;
      M_AWREADY = M_AWVALID && aw_c >= dly_aw;
      aw_c      = M_AWVALID ? aw_c + 1 : 0;
      M_WREADY  = M_WVALID && w_c >= dly_w;
      w_c       = M_WVALID ? w_c + 1 : 0;
      M_BVALID  = M_BREADY && b_c >= dly_b;
      b_c       = M_BREADY ? b_c + 1 : 0;
      M_ARREADY = M_ARVALID && ar_c >= dly_ar;
      ar_c      = M_ARVALID ? ar_c + 1 : 0;
      M_RVALID  = M_RREADY && r_c >= dly_r;
      r_c       = M_RREADY ? r_c + 1 : 0;
   end

   always @(posedge CLK) begin
      if (M_AWVALID && M_AWREADY) begin aw_s = M_AWADDR; aw_n++; end
      if (M_WVALID && M_WREADY) begin w_s = M_WDATA; s_s = M_WSTRB; end
      if (M_ARVALID && M_ARREADY) ar_s = M_ARADDR;
      if (DONE_WRITE) dw_n++;
      if (DONE_READ) dr_n++;
   end

   function automatic logic [8:0] ctrl_vec();
      return {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, BUSY_WRITE, BUSY_READ, DONE_WRITE, DONE_READ};
   endfunction

   task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r);
      dly_aw = aw; dly_w = w; dly_b = b; dly_ar = ar; dly_r = r;
   endtask

   task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit push);
      TRANSACTION_WRADDR = a; TRANSACTION_WRDATA = d; TRANSACTION_WSTRB = s; START_WRITE = 1'b1;
      if (push) wq.push_back('{a, d, s});
   endtask

   task automatic start_rd(input logic [31:0] a, input logic [31:0] d, input bit push);
      TRANSACTION_RADDR = a; START_READ = 1'b1;
      if (push) rq.push_back('{a, d});
   endtask

   task automatic test_reset;
      repeat (2) @(negedge CLK);
      checks++;
      if (ctrl_vec() !== 9'd0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", ctrl_vec()); end
      checks++;
      if ({M_AWADDR, M_WDATA, M_WSTRB, M_ARADDR, TRANSACTION_RDATA, M_AWPROT, M_ARPROT} !== '0) begin
         failures++; $display("FAIL reset_data awaddr=%h wdata=%h wstrb=%h araddr=%h rdata=%h exp=0", M_AWADDR, M_WDATA, M_WSTRB, M_ARADDR, TRANSACTION_RDATA);
      end
`ifdef AXIL_RESP_ERR_EN
      checks++;
      if ({WRITE_ERR, READ_ERR} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {WRITE_ERR, READ_ERR}); end
`endif
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (ctrl_vec() !== 9'd0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", ctrl_vec()); end
   endtask

   task automatic test_write_basic;
      int dw0 = dw_n;
      wexp_t e;
      set_slave(0, 0, 0, 0, 0);
      @(negedge CLK);
      start_wr(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         START_WRITE = 1'b0;
         checks++;
         if ({M_AWVALID & M_AWREADY, M_WVALID & M_WREADY, M_BVALID & M_BREADY, DONE_WRITE, BUSY_WRITE} !== {c == 1, c == 1, c == 2, c == 3, c <= 2}) begin
            failures++; $display("FAIL wr_basic_c%0d aw_hs/w_hs/b_hs/done/busy got=%b%b%b%b%b", c, M_AWVALID & M_AWREADY, M_WVALID & M_WREADY, M_BVALID & M_BREADY, DONE_WRITE, BUSY_WRITE);
         end
         if (DONE_WRITE) begin
            checks++;
            if (wq.size() == 0) begin failures++; $display("FAIL wr_basic_sb unexpected DONE_WRITE"); end
            else begin
               e = wq.pop_front();
               if ({aw_s, w_s, s_s} !== {e.addr, e.data, e.strb}) begin failures++; $display("FAIL wr_basic_sb got=%h/%h/%h exp=%h/%h/%h", aw_s, w_s, s_s, e.addr, e.data, e.strb); end
            end
         end
      end
      checks++;
      if (dw_n - dw0 !== 1) begin failures++; $display("FAIL wr_basic_done_count got=%0d exp=1", dw_n - dw0); end
   endtask

   task automatic test_write_aw_delay;
      int dw0 = dw_n;
      wexp_t e;
      set_slave(3, 0, 0, 0, 0);
      @(negedge CLK);
      start_wr(32'h4000_0200, 32'h0BAD_CAFE, 4'h5, 1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         START_WRITE = 1'b0;
         checks++;
         if ({M_AWVALID, M_WVALID, M_BREADY, DONE_WRITE, BUSY_WRITE} !== {c <= 4, c == 1, c == 5, c == 6, c <= 5}) begin
            failures++; $display("FAIL wr_awdly_c%0d awvalid/wvalid/bready/done/busy got=%b%b%b%b%b", c, M_AWVALID, M_WVALID, M_BREADY, DONE_WRITE, BUSY_WRITE);
         end
         if (DONE_WRITE) begin
            checks++;
            if (wq.size() == 0) begin failures++; $display("FAIL wr_awdly_sb unexpected DONE_WRITE"); end
            else begin
               e = wq.pop_front();
               if ({aw_s, w_s, s_s} !== {e.addr, e.data, e.strb}) begin failures++; $display("FAIL wr_awdly_sb got=%h/%h/%h exp=%h/%h/%h", aw_s, w_s, s_s, e.addr, e.data, e.strb); end
            end
         end
      end
      checks++;
      if (dw_n - dw0 !== 1) begin failures++; $display("FAIL wr_awdly_done_count got=%0d exp=1", dw_n - dw0); end
   endtask

   task automatic test_read_delay;
      int dr0 = dr_n;
      rexp_t e;
      set_slave(0, 0, 0, 0, 5);
      rdata_v = 32'h1234_5678;
      @(negedge CLK);
      start_rd(32'h4000_0300, 32'h1234_5678, 1);
      for (int c = 1; c <= 9; c++) begin
         @(negedge CLK);
         START_READ = 1'b0;
         checks++;
         if ({M_ARVALID, M_RREADY, M_RVALID & M_RREADY, DONE_READ, BUSY_READ} !== {c == 1, c >= 2 && c <= 7, c == 7, c == 8, c <= 7}) begin
            failures++; $display("FAIL rd_dly_c%0d arvalid/rready/r_hs/done/busy got=%b%b%b%b%b", c, M_ARVALID, M_RREADY, M_RVALID & M_RREADY, DONE_READ, BUSY_READ);
         end
         if (DONE_READ) begin
            checks++;
            if (rq.size() == 0) begin failures++; $display("FAIL rd_dly_sb unexpected DONE_READ"); end
            else begin
               e = rq.pop_front();
               if ({ar_s, TRANSACTION_RDATA} !== {e.addr, e.data}) begin failures++; $display("FAIL rd_dly_sb got=%h/%h exp=%h/%h", ar_s, TRANSACTION_RDATA, e.addr, e.data); end
            end
         end
      end
      checks++;
      if (TRANSACTION_RDATA !== 32'h1234_5678) begin failures++; $display("FAIL rd_dly_hold got=%h exp=12345678", TRANSACTION_RDATA); end
      checks++;
      if (dr_n - dr0 !== 1) begin failures++; $display("FAIL rd_dly_done_count got=%0d exp=1", dr_n - dr0); end
   endtask

   task automatic test_concurrent;
      int dw0 = dw_n, dr0 = dr_n, aw0 = aw_n;
      wexp_t we;
      rexp_t re;
      set_slave(0, 0, 0, 0, 0);
      rdata_v = 32'hCAFE_F00D;
      @(negedge CLK);
      start_wr(32'h0000_0100, 32'h1111_1111, 4'h3, 1);
      start_rd(32'h0000_0200, 32'hCAFE_F00D, 1);
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         START_WRITE = 1'b0;
         START_READ  = 1'b0;
         if (c == 1) begin
            start_wr(32'h0000_0999, 32'h9999_9999, 4'h1, 0);
            start_rd(32'h0000_0888, 32'h0, 0);
         end
         checks++;
         if ({DONE_WRITE, DONE_READ, BUSY_WRITE, BUSY_READ} !== {c == 3, c == 3, c <= 2, c <= 2}) begin
            failures++; $display("FAIL conc_c%0d done_w/done_r/busy_w/busy_r got=%b%b%b%b", c, DONE_WRITE, DONE_READ, BUSY_WRITE, BUSY_READ);
         end
         if (DONE_WRITE) begin
            checks++;
            if (wq.size() == 0) begin failures++; $display("FAIL conc_wr_sb unexpected DONE_WRITE"); end
            else begin
               we = wq.pop_front();
               if ({aw_s, w_s, s_s} !== {we.addr, we.data, we.strb}) begin failures++; $display("FAIL conc_wr_sb got=%h/%h/%h exp=%h/%h/%h", aw_s, w_s, s_s, we.addr, we.data, we.strb); end
            end
         end
         if (DONE_READ) begin
            checks++;
            if (rq.size() == 0) begin failures++; $display("FAIL conc_rd_sb unexpected DONE_READ"); end
            else begin
               re = rq.pop_front();
               if ({ar_s, TRANSACTION_RDATA} !== {re.addr, re.data}) begin failures++; $display("FAIL conc_rd_sb got=%h/%h exp=%h/%h", ar_s, TRANSACTION_RDATA, re.addr, re.data); end
            end
         end
      end
      checks++;
      if ({dw_n - dw0, dr_n - dr0, aw_n - aw0} !== {32'd1, 32'd1, 32'd1}) begin
         failures++; $display("FAIL conc_counts done_w=%0d done_r=%0d aw_hs=%0d exp=1/1/1", dw_n - dw0, dr_n - dr0, aw_n - aw0);
      end
   endtask

   task automatic test_back_to_back;
      int dw0 = dw_n, dr0 = dr_n;
      wexp_t we;
      rexp_t re;
      set_slave(0, 0, 0, 0, 0);
      rdata_v = 32'hAAAA_0001;
      @(negedge CLK);
      start_wr(32'h0000_1000, 32'h0101_0101, 4'hF, 1);
      start_rd(32'h0000_2000, 32'hAAAA_0001, 1);
      for (int c = 1; c <= 7; c++) begin
         @(negedge CLK);
         START_WRITE = 1'b0;
         START_READ  = 1'b0;
         checks++;
         if ({DONE_WRITE, BUSY_WRITE, DONE_READ, BUSY_READ} !== {c == 3 || c == 6, c == 1 || c == 2 || c == 4 || c == 5, c == 3 || c == 6, c == 1 || c == 2 || c == 4 || c == 5}) begin
            failures++; $display("FAIL b2b_c%0d done_w/busy_w/done_r/busy_r got=%b%b%b%b", c, DONE_WRITE, BUSY_WRITE, DONE_READ, BUSY_READ);
         end
         if (DONE_WRITE) begin
            checks++;
            if (wq.size() == 0) begin failures++; $display("FAIL b2b_wr_sb unexpected DONE_WRITE"); end
            else begin
               we = wq.pop_front();
               if ({aw_s, w_s, s_s} !== {we.addr, we.data, we.strb}) begin failures++; $display("FAIL b2b_wr_sb got=%h/%h/%h exp=%h/%h/%h", aw_s, w_s, s_s, we.addr, we.data, we.strb); end
            end
         end
         if (DONE_READ) begin
            checks++;
            if (rq.size() == 0) begin failures++; $display("FAIL b2b_rd_sb unexpected DONE_READ"); end
            else begin
               re = rq.pop_front();
               if ({ar_s, TRANSACTION_RDATA} !== {re.addr, re.data}) begin failures++; $display("FAIL b2b_rd_sb got=%h/%h exp=%h/%h", ar_s, TRANSACTION_RDATA, re.addr, re.data); end
            end
         end
         if (c == 3) begin
            rdata_v = 32'hBBBB_0002;
            start_wr(32'h0000_1004, 32'h0202_0202, 4'hC, 1);
            start_rd(32'h0000_2004, 32'hBBBB_0002, 1);
         end
      end
      checks++;
      if ({dw_n - dw0, dr_n - dr0} !== {32'd2, 32'd2}) begin failures++; $display("FAIL b2b_counts done_w=%0d done_r=%0d exp=2/2", dw_n - dw0, dr_n - dr0); end
   endtask

   task automatic test_reset_mid;
      int dw0, dr0;
      set_slave(0, 0, 10, 10, 0);
      @(negedge CLK);
      start_wr(32'h0000_3000, 32'h3333_3333, 4'hF, 1);
      start_rd(32'h0000_4000, 32'h0, 1);
      @(negedge CLK);
      START_WRITE = 1'b0;
      START_READ  = 1'b0;
      @(negedge CLK);
      checks++;
      if ({M_BREADY, M_ARVALID, BUSY_WRITE, BUSY_READ} !== 4'b1111) begin
         failures++; $display("FAIL rstmid_pre bready/arvalid/busy_w/busy_r got=%b exp=1111", {M_BREADY, M_ARVALID, BUSY_WRITE, BUSY_READ});
      end
      dw0 = dw_n;
      dr0 = dr_n;
      RST_N = 1'b0;
      #1;
      checks++;
      if (ctrl_vec() !== 9'd0) begin failures++; $display("FAIL rstmid_async got=%b exp=0", ctrl_vec()); end
      wq.delete();
      rq.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      set_slave(0, 0, 0, 0, 0);
      repeat (6) @(negedge CLK);
      checks++;
      if ({dw_n - dw0, dr_n - dr0} !== {32'd0, 32'd0}) begin failures++; $display("FAIL rstmid_no_done done_w=%0d done_r=%0d exp=0/0", dw_n - dw0, dr_n - dr0); end
      checks++;
      if (ctrl_vec() !== 9'd0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", ctrl_vec()); end
   endtask

   task automatic test_resp;
      int dw0 = dw_n, dr0 = dr_n;
      rexp_t re;
      set_slave(0, 0, 0, 0, 0);
      rdata_v = 32'h55AA_55AA;
      bresp_v = 2'b11;
      rresp_v = 2'b10;
      @(negedge CLK);
      start_wr(32'h0000_5000, 32'h5555_5555, 4'hF, 1);
      start_rd(32'h0000_6000, ERR_EN ? 32'h0 : 32'h55AA_55AA, 1);
      for (int c = 1; c <= 5; c++) begin
         @(negedge CLK);
         START_WRITE = 1'b0;
         START_READ  = 1'b0;
         checks++;
         if ({DONE_WRITE, DONE_READ} !== {c == 3, c == 3}) begin failures++; $display("FAIL resp_c%0d done_w/done_r got=%b%b", c, DONE_WRITE, DONE_READ); end
`ifdef AXIL_RESP_ERR_EN
         checks++;
         if ({WRITE_ERR, READ_ERR} !== {c == 3, c == 3}) begin failures++; $display("FAIL resp_err_c%0d write_err/read_err got=%b%b", c, WRITE_ERR, READ_ERR); end
`endif
         if (DONE_WRITE) void'(wq.pop_front());
         if (DONE_READ) begin
            checks++;
            if (rq.size() == 0) begin failures++; $display("FAIL resp_rd_sb unexpected DONE_READ"); end
            else begin
               re = rq.pop_front();
               if ({ar_s, TRANSACTION_RDATA} !== {re.addr, re.data}) begin failures++; $display("FAIL resp_rd_sb got=%h/%h exp=%h/%h", ar_s, TRANSACTION_RDATA, re.addr, re.data); end
            end
         end
      end
      checks++;
      if ({dw_n - dw0, dr_n - dr0} !== {32'd1, 32'd1}) begin failures++; $display("FAIL resp_counts done_w=%0d done_r=%0d exp=1/1", dw_n - dw0, dr_n - dr0); end
      bresp_v = 2'b00;
      rresp_v = 2'b00;
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_write_aw_delay();
      test_read_delay();
      test_concurrent();
      test_back_to_back();
      test_reset_mid();
      test_resp();
      checks++;
      if (wq.size() + rq.size() != 0) begin failures++; $display("FAIL sb_leftover wr=%0d rd=%0d exp=0/0", wq.size(), rq.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axil_master.md
# axil_master

AXI4-Lite master bridge between the dtcore32 memory stage and the external peripheral bus. It accepts single-beat read/write requests on the core's start/done/busy transaction interface and runs them as AXI4-Lite transactions. It returns completion pulses and read data to the core. Read and write paths are independent and may be active at the same time.

## Interface
- ADDR_WIDTH, 32: AXI and transaction address width.
- DATA_WIDTH, 32: data width; must be 32; strobe width is DATA_WIDTH/8.
- CLK  in  1  sole clock; all logic rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- START_WRITE / START_READ  in  1  one-cycle request pulses from the core.
- TRANSACTION_WRADDR  in  ADDR_WIDTH  write address; sampled with START_WRITE.
- TRANSACTION_WRDATA  in  DATA_WIDTH  write data; sampled with START_WRITE.
- TRANSACTION_WSTRB  in  4  byte strobes; sampled with START_WRITE.
- TRANSACTION_RADDR  in  ADDR_WIDTH  read address; sampled with START_READ.
- TRANSACTION_RDATA  out  DATA_WIDTH  registered read result; valid from DONE_READ until the next read completes.
- DONE_WRITE / DONE_READ  out  1  one-cycle completion pulses.
- BUSY_WRITE / BUSY_READ  out  1  high while the corresponding FSM is not IDLE.
- M_AWADDR, M_AWPROT(3, always 3'b000), M_AWVALID, M_AWREADY(in): write address channel.
- M_WDATA, M_WSTRB(4), M_WVALID, M_WREADY(in): write data channel.
- M_BRESP(in, 2), M_BVALID(in), M_BREADY: write response channel.
- M_ARADDR, M_ARPROT(3, always 3'b000), M_ARVALID, M_ARREADY(in): read address channel.
- M_RDATA(in), M_RRESP(in, 2), M_RVALID(in), M_RREADY: read data channel.
- WRITE_ERR / READ_ERR  out  1  present only under AXIL_RESP_ERR_EN.

## Operation
- Write FSM states are W_IDLE, W_ADDR, W_RESP.
  - W_IDLE to W_ADDR on START_WRITE. Address, data and strobe are registered. AWVALID and WVALID rise next cycle.
  - In W_ADDR, the AW and W handshakes complete independently. Each VALID drops the cycle after its own handshake. Two sticky done flags track them.
  - W_ADDR to W_RESP once both handshakes are done, including when both complete in the same cycle. BREADY is high in W_RESP.
  - W_RESP to W_IDLE on BVALID&BREADY. DONE_WRITE pulses in the following cycle.
- Read FSM states are R_IDLE, R_ADDR, R_DATA.
  - R_IDLE to R_ADDR on START_READ; the address is registered. ARVALID is high in R_ADDR.
  - R_ADDR to R_DATA on the AR handshake. RREADY is high in R_DATA.
  - R_DATA to R_IDLE on RVALID&RREADY. M_RDATA is captured into TRANSACTION_RDATA. DONE_READ pulses in the following cycle.
- A START while the matching FSM is not idle is ignored: no queueing, no error. A START in the DONE cycle is accepted, because the FSM is already IDLE.
- VALID signals never drop before their handshake, per AXI4-Lite.
- BRESP and RRESP are ignored unless AXIL_RESP_ERR_EN is defined.

## Timing
- Reset values: every VALID/READY output, BUSY_*, DONE_* and *_ERR are 0. M_* address/data/strobe and TRANSACTION_RDATA are 0. Both FSMs are IDLE.
- Reset mid-transaction returns both FSMs to IDLE immediately; the transaction is abandoned.
- BUSY_x rises the cycle after START_x. It falls in the same cycle DONE_x pulses.
- Minimum write latency, with all READY/VALID inputs high: START at cycle 0, AW/W handshake at 1, B handshake at 2, DONE_WRITE at 3.
- Minimum read latency: START at 0, AR handshake at 1, R handshake at 2, DONE_READ at 3.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- AXIL_RESP_ERR_EN defined:
  - WRITE_ERR/READ_ERR are registered with DONE_*. Each is high for the DONE cycle if the captured RESP is SLVERR (2'b10) or DECERR (2'b11).
  - On a read error, TRANSACTION_RDATA is forced to 0.
- AXIL_RESP_ERR_EN undefined: the ports are absent, responses are ignored, and RDATA is always captured.

## Test plan
- Write with a slave that is always ready: START_WRITE at addr 0x4000_0010, data 0xDEAD_BEEF, strobe 4'hF -> AW/W handshake at cycle 1 with those values, DONE_WRITE at cycle 3, BUSY_WRITE high in cycles 1-2 only.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after cycle 1, AWVALID holds until accepted, BREADY rises only after both handshakes, exactly one DONE_WRITE.
- Read with RVALID delayed 5 cycles, M_RDATA 0x1234_5678 -> RREADY held throughout, TRANSACTION_RDATA 0x1234_5678 alongside DONE_READ, BUSY_READ falls with DONE_READ.
- Concurrent START_WRITE and START_READ in the same cycle -> both complete independently, each DONE pulses once, a second START during BUSY is ignored.
- RST_N low while in W_RESP and R_ADDR -> all VALID/READY/BUSY outputs 0 immediately, and no DONE pulse follows release.
- With AXIL_RESP_ERR_EN defined, RRESP 2'b10 -> READ_ERR=1 with DONE_READ and TRANSACTION_RDATA=0; BRESP 2'b11 -> WRITE_ERR=1 with DONE_WRITE.
